// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath: ALU opcodes and bus-source ordering.
package datapath_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_MUL  = 5'b10000,
    OP_DIV  = 5'b10001,
    OP_NEG  = 5'b10010,
    OP_NOT  = 5'b10011
  } alu_op_e;

  // Bus sources by priority: a lower index wins when several selects are high.
  localparam int NUM_GPR    = 16;
  localparam int BUS_R0     = 0;
  localparam int BUS_HI     = 16;
  localparam int BUS_LO     = 17;
  localparam int BUS_ZHI    = 18;
  localparam int BUS_ZLO    = 19;
  localparam int BUS_PC     = 20;
  localparam int BUS_MDR    = 21;
  localparam int BUS_INPORT = 22;
  localparam int BUS_NSRC   = 23;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU, A op B -> 64-bit result. Divide exists only when
// DATAPATH_DIV_EN is defined; otherwise opcode 10001 returns 0.
module alu
  import datapath_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  opcode,
  output logic [63:0] result
);

  logic [5:0]         w_sh;
  logic [5:0]         w_nsh;
  logic [63:0]        w_dbl;
  logic [31:0]        w_shra;
  logic signed [63:0] w_prod;

  assign w_sh   = {1'b0, B[4:0]};
  assign w_nsh  = {1'b0, 5'd0 - B[4:0]};
  assign w_dbl  = {A, A};
  assign w_shra = $signed(A) >>> B[4:0];
  assign w_prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

`ifdef DATAPATH_DIV_EN
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  // Guarded so a zero divisor never reaches the divider output.
  assign w_quo = (B == 32'd0) ? 32'd0 : 32'($signed(A) / $signed(B));
  assign w_rem = (B == 32'd0) ? 32'd0 : 32'($signed(A) % $signed(B));
`endif

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = {32'd0, A + B};
      OP_SUB:  result = {32'd0, A - B};
      OP_AND:  result = {32'd0, A & B};
      OP_OR:   result = {32'd0, A | B};
      OP_SHR:  result = {32'd0, A >> B[4:0]};
      OP_SHRA: result = {32'd0, w_shra};
      OP_SHL:  result = {32'd0, A << B[4:0]};
      OP_ROR:  result = {32'd0, w_dbl[w_sh +: 32]};
      OP_ROL:  result = {32'd0, w_dbl[w_nsh +: 32]};
      OP_MUL:  result = w_prod;
`ifdef DATAPATH_DIV_EN
      OP_DIV:  result = {w_rem, w_quo};
`endif
      OP_NEG:  result = {32'd0, 32'd0 - B};
      OP_NOT:  result = {32'd0, ~B};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: register file, special registers, priority bus mux and ALU/Z.
// Optional divider controlled by DATAPATH_DIV_EN (see alu).
module datapath
  import datapath_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        PCin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        MARin,
  input  logic        Yin,
  input  logic        InPortIn,
  input  logic        MDRin,
  input  logic        read,
  input  logic        Zin,
  input  logic        incPC,
  input  logic [4:0]  opcode,
  input  logic [31:0] Mdatain,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        PCout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        ZHighOut,
  input  logic        ZLowOut,
  input  logic        MDRout,
  input  logic        InPortOut,
  output logic [31:0] BusMuxOut
);

  logic [31:0] r_gpr [NUM_GPR];
  logic [31:0] r_pc, r_hi, r_lo, r_mar, r_mdr, r_y, r_inport;
  logic [63:0] r_z;

  logic [NUM_GPR-1:0]  w_gpr_in;
  logic [BUS_NSRC-1:0] w_sel;
  logic [31:0]         w_src [BUS_NSRC];
  logic [31:0]         w_bus;
  logic [63:0]         w_alu;

  assign w_gpr_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  assign w_sel = {InPortOut, MDRout, PCout, ZLowOut, ZHighOut, LOout, HIout,
                  R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  for (genvar g = 0; g < NUM_GPR; g++) begin : g_src
    assign w_src[BUS_R0 + g] = r_gpr[g];
  end
  assign w_src[BUS_HI]     = r_hi;
  assign w_src[BUS_LO]     = r_lo;
  assign w_src[BUS_ZHI]    = r_z[63:32];
  assign w_src[BUS_ZLO]    = r_z[31:0];
  assign w_src[BUS_PC]     = r_pc;
  assign w_src[BUS_MDR]    = r_mdr;
  assign w_src[BUS_INPORT] = r_inport;

  // Scan from the highest index down so the lowest asserted index is left on the bus.
  always_comb begin
    w_bus = '0;
    for (int i = BUS_NSRC - 1; i >= 0; i--) begin
      if (w_sel[i]) w_bus = w_src[i];
    end
  end

  assign BusMuxOut = w_bus;

  alu u_alu (
    .A      (r_y),
    .B      (w_bus),
    .opcode (opcode),
    .result (w_alu)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
      r_pc     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_y      <= '0;
      r_inport <= '0;
      r_z      <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (w_gpr_in[i]) r_gpr[i] <= w_bus;
      end
      if (incPC)         r_pc <= r_pc + 32'd1;
      else if (PCin)     r_pc <= w_bus;
      if (HIin)          r_hi     <= w_bus;
      if (LOin)          r_lo     <= w_bus;
      if (MARin)         r_mar    <= w_bus;
      if (Yin)           r_y      <= w_bus;
      if (InPortIn)      r_inport <= w_bus;
      if (MDRin)         r_mdr    <= read ? Mdatain : w_bus;
      if (Zin)           r_z      <= w_alu;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath; expectations queued by stimulus, compared by a negedge monitor.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] gin;
  logic        PCin, HIin, LOin, MARin, Yin, InPortIn, MDRin, read, Zin, incPC;
  logic [4:0]  opcode;
  logic [31:0] Mdatain;
  // 0..15 R0..R15, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR, 22 InPort
  logic [22:0] tsel;
  logic [31:0] BusMuxOut;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          src_mar;
  } exp_t;

  exp_t        sb_q[$];
  logic        chk_req = 1'b0;
  int          checks  = 0;
  int          errors  = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  always #5 clock = ~clock;

  datapath dut (
    .clock(clock), .clear(clear),
    .R0in(gin[0]),   .R1in(gin[1]),   .R2in(gin[2]),   .R3in(gin[3]),
    .R4in(gin[4]),   .R5in(gin[5]),   .R6in(gin[6]),   .R7in(gin[7]),
    .R8in(gin[8]),   .R9in(gin[9]),   .R10in(gin[10]), .R11in(gin[11]),
    .R12in(gin[12]), .R13in(gin[13]), .R14in(gin[14]), .R15in(gin[15]),
    .PCin(PCin), .HIin(HIin), .LOin(LOin), .MARin(MARin), .Yin(Yin),
    .InPortIn(InPortIn), .MDRin(MDRin), .read(read), .Zin(Zin), .incPC(incPC),
    .opcode(opcode), .Mdatain(Mdatain),
    .R0out(tsel[0]),   .R1out(tsel[1]),   .R2out(tsel[2]),   .R3out(tsel[3]),
    .R4out(tsel[4]),   .R5out(tsel[5]),   .R6out(tsel[6]),   .R7out(tsel[7]),
    .R8out(tsel[8]),   .R9out(tsel[9]),   .R10out(tsel[10]), .R11out(tsel[11]),
    .R12out(tsel[12]), .R13out(tsel[13]), .R14out(tsel[14]), .R15out(tsel[15]),
    .HIout(tsel[16]), .LOout(tsel[17]), .ZHighOut(tsel[18]), .ZLowOut(tsel[19]),
    .PCout(tsel[20]), .MDRout(tsel[21]), .InPortOut(tsel[22]),
    .BusMuxOut(BusMuxOut)
  );

  always @(negedge clock) begin
    if (chk_req) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: monitor strobed with no expected value queued");
      end else begin
        mon_e   = sb_q.pop_front();
        mon_act = mon_e.src_mar ? dut.r_mar : BusMuxOut;
        if (mon_act !== mon_e.exp) begin
          errors++;
          $display("FAIL %s: got %08h expected %08h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  task automatic clr();
    gin = '0; tsel = '0; opcode = '0; Mdatain = '0;
    PCin = 0; HIin = 0; LOin = 0; MARin = 0; Yin = 0; InPortIn = 0;
    MDRin = 0; read = 0; Zin = 0; incPC = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clr();
  endtask

  // Caller sets the output selects; the monitor samples on the following negedge.
  task automatic check(input string name, input logic [31:0] exp, input bit src_mar = 0);
    exp_t e;
    e.name = name; e.exp = exp; e.src_mar = src_mar;
    sb_q.push_back(e);
    chk_req = 1'b1;
    @(posedge clock);
    #1;
    chk_req = 1'b0;
    clr();
  endtask

  task automatic load_mdr(input logic [31:0] val);
    Mdatain = val; read = 1; MDRin = 1; step();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] val);
    load_mdr(val);
    tsel[21] = 1; gin[idx] = 1; step();
  endtask

  task automatic alu_op(input int a, input int b, input logic [4:0] op);
    tsel[a] = 1; Yin = 1; step();
    tsel[b] = 1; opcode = op; Zin = 1; step();
  endtask

  task automatic check_z(input string name, input logic [31:0] hi, input logic [31:0] lo);
    tsel[19] = 1; check({name, "_zlo"}, lo);
    tsel[18] = 1; check({name, "_zhi"}, hi);
  endtask

  initial begin
    clr();
    clear = 1;
    repeat (2) @(posedge clock);
    #1;
    clear = 0;

    check("rst_nosel", 32'h0);
    tsel[0] = 1;  check("rst_r0", 32'h0);
    tsel[20] = 1; check("rst_pc", 32'h0);

    load_reg(4, 32'd10);
    load_reg(5, 32'd22);
    load_reg(7, 32'h8000_0010);
    load_reg(8, 32'd4);
    load_reg(10, 32'd36);
    load_reg(11, 32'd8);
    load_reg(1, 32'h0001_0000);
    load_reg(2, 32'hFFFF_FFFE);
    load_reg(12, 32'd3);

    alu_op(4, 5, 5'b00101);
    tsel[19] = 1; gin[9] = 1; step();
    tsel[9] = 1;  check("and_r9", 32'd2);
    tsel[18] = 1; check("and_zhi", 32'd0);

    alu_op(4, 5, 5'b00011);
    tsel[19] = 1; gin[9] = 1; step();
    tsel[9] = 1;  check("add_r9", 32'd32);

    alu_op(4, 5, 5'b00100);  check_z("sub", 32'h0, 32'hFFFF_FFF4);
    alu_op(4, 5, 5'b00110);  check_z("or", 32'h0, 32'd30);
    alu_op(1, 1, 5'b10000);  check_z("mul", 32'h1, 32'h0);
    alu_op(2, 12, 5'b10000); check_z("mulneg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    alu_op(4, 0, 5'b10001);  check_z("div0", 32'h0, 32'h0);
    alu_op(5, 4, 5'b10001);
`ifdef DATAPATH_DIV_EN
    check_z("div", 32'd2, 32'd2);
`else
    check_z("div_off", 32'h0, 32'h0);
`endif
    alu_op(7, 8, 5'b00111);  check_z("shr", 32'h0, 32'h0800_0001);
    alu_op(7, 8, 5'b01000);  check_z("shra", 32'h0, 32'hF800_0001);
    alu_op(7, 10, 5'b01001); check_z("shl36", 32'h0, 32'h0000_0100);
    alu_op(7, 11, 5'b01010); check_z("ror8", 32'h0, 32'h1080_0000);
    alu_op(7, 8, 5'b01011);  check_z("rol4", 32'h0, 32'h0000_0108);
    alu_op(7, 0, 5'b00111);  check_z("shr0", 32'h0, 32'h8000_0010);
    alu_op(7, 4, 5'b10010);  check_z("neg", 32'h0, 32'hFFFF_FFF6);
    alu_op(7, 4, 5'b10011);  check_z("not", 32'h0, 32'hFFFF_FFF5);
    alu_op(7, 4, 5'b11010);  check_z("badop", 32'h0, 32'h0);

    load_reg(3, 32'h33);
    load_reg(13, 32'hAA); tsel[13] = 1; HIin = 1; step();
    load_reg(13, 32'hBB); tsel[13] = 1; LOin = 1; step();
    load_reg(13, 32'hCC); tsel[13] = 1; InPortIn = 1; step();
    load_mdr(32'h5A5A_5A5A);
    check("bus_nosel", 32'h0);
    tsel[3] = 1; tsel[21] = 1;  check("bus_r3_mdr", 32'h33);
    tsel[16] = 1; tsel[20] = 1; check("bus_hi_pc", 32'hAA);
    tsel[17] = 1;               check("bus_lo", 32'hBB);
    tsel[22] = 1;               check("bus_inport", 32'hCC);
    tsel[21] = 1; tsel[22] = 1; check("bus_mdr_inport", 32'h5A5A_5A5A);
    alu_op(2, 12, 5'b10000);
    tsel[18] = 1; tsel[19] = 1; check("bus_zhi_zlo", 32'hFFFF_FFFF);
    tsel[3] = 1; MDRin = 1; read = 0; step();
    tsel[21] = 1;               check("mdr_from_bus", 32'h33);

    load_mdr(32'hFFFF_FFFF);
    tsel[21] = 1; PCin = 1; step();
    tsel[20] = 1; check("pc_load", 32'hFFFF_FFFF);
    load_mdr(32'h1234_5678);
    tsel[21] = 1; PCin = 1; incPC = 1; step();
    tsel[20] = 1; check("pc_wrap", 32'h0);
    incPC = 1; step();
    tsel[20] = 1; MARin = 1; step();
    check("mar_pc", 32'h1, 1'b1);

    alu_op(4, 5, 5'b00011);
    tsel[4] = 1; gin[6] = 1; Yin = 1; Zin = 1; opcode = 5'b00011;
    incPC = 1; HIin = 1; clear = 1;
    step();
    clear = 0;
    for (int i = 0; i < 23; i++) begin
      tsel[i] = 1;
      check($sformatf("rst_sel%0d", i), 32'h0);
    end
    check("rst_mar", 32'h0, 1'b1);

    repeat (2) @(posedge clock);
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
